bin2bcd_disp: RTL and testbench

BIN2BCD_DISP -- requirements
Module: bin2bcd_disp

---
 rtl/bin2bcd_disp.sv | 150 +++++++++++++++
 tb/tb_bin2bcd_disp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_disp.sv
// Binary-to-BCD converter for an eight-digit frequency display: double-dabble
// conversion with clamping, optional leading-zero blanking and decimal-point hints.
module bin2bcd_disp #(
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Bin_Data,
    input  logic        Bin_Valid,
    output logic [31:0] Disp_Data,
    output logic [2:0]  point_1,
    output logic [2:0]  point_2,
    output logic        Ovf,
    output logic        Busy,
    output logic        Done
);

    localparam logic [31:0] MAX_VAL    = 32'd99_999_999;
    localparam logic [26:0] MAX_VAL27  = 27'd99_999_999;
    localparam logic [31:0] RESET_DISP = BLANK_EN ? 32'hFFFF_FFF0 : 32'h0000_0000;
    localparam logic [4:0]  LAST_SHIFT = 5'd26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t      state_q;
    logic [26:0] sr_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic        clamp_q;
    logic        pend_q;
    logic [31:0] pend_data_q;
    logic [31:0] disp_q;
    logic [2:0]  point_1_q;
    logic [2:0]  point_2_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] src_d;
    logic        src_ovf_d;
    logic [26:0] src_clamped_d;
    logic [31:0] acc_adj_d;
    logic [31:0] disp_d;
    logic [2:0]  point_1_d;
    logic [2:0]  point_2_d;

    // A fresh Bin_Valid in IDLE always beats the buffered value.
    always_comb begin
        src_d         = Bin_Valid ? Bin_Data : pend_data_q;
        src_ovf_d     = (src_d > MAX_VAL);
        src_clamped_d = src_ovf_d ? MAX_VAL27 : src_d[26:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign acc_adj_d[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5)
                                        ? acc_q[gi*4 +: 4] + 4'd3
                                        : acc_q[gi*4 +: 4];

            // A digit is blanked when it and every digit above it are zero.
            if (gi == 0) begin : g_units
                assign disp_d[3:0] = acc_q[3:0];
            end else begin : g_upper
                assign disp_d[gi*4 +: 4] = (BLANK_EN && !(|acc_q[31:gi*4]))
                                         ? 4'hF
                                         : acc_q[gi*4 +: 4];
            end
        end
    endgenerate

    // Thresholds follow from the finished BCD digits: >= 1_000 means any of
    // digits 3..7 is non-zero, >= 1_000_000 means any of digits 6..7 is.
    always_comb begin
        point_1_d = (|acc_q[31:12]) ? 3'd3 : 3'd0;
        point_2_d = (|acc_q[31:24]) ? 3'd6 : 3'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            clamp_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            disp_q      <= RESET_DISP;
            point_1_q   <= '0;
            point_2_q   <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (busy_q && Bin_Valid) begin
                pend_q      <= 1'b1;
                pend_data_q <= Bin_Data;
            end

            case (state_q)
                IDLE: begin
                    if (Bin_Valid || pend_q) begin
                        sr_q    <= src_clamped_d;
                        clamp_q <= src_ovf_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= 32'({acc_adj_d, sr_q[26]});
                    sr_q  <= {sr_q[25:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_SHIFT) begin
                        state_q <= FORMAT;
                    end
                end
                FORMAT: begin
                    disp_q    <= disp_d;
                    point_1_q <= point_1_d;
                    point_2_q <= point_2_d;
                    ovf_q     <= clamp_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Disp_Data = disp_q;
    assign point_1   = point_1_q;
    assign point_2   = point_2_q;
    assign Ovf       = ovf_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Scoreboard bench for bin2bcd_disp: one blanking and one plain-BCD instance share
// the stimulus; a monitor pops expected results on every Done pulse.
module tb_bin2bcd_disp;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Bin_Data;
    logic        Bin_Valid;

    logic [31:0] disp1, disp0;
    logic [2:0]  p1_1, p2_1, p1_0, p2_0;
    logic        ovf1, ovf0, busy1, busy0, done1, done0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        logic [2:0]  p1;
        logic [2:0]  p2;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    bin2bcd_disp #(.BLANK_EN(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .Bin_Data(Bin_Data), .Bin_Valid(Bin_Valid),
        .Disp_Data(disp1), .point_1(p1_1), .point_2(p2_1),
        .Ovf(ovf1), .Busy(busy1), .Done(done1)
    );

    bin2bcd_disp #(.BLANK_EN(1'b0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Bin_Data(Bin_Data), .Bin_Valid(Bin_Valid),
        .Disp_Data(disp0), .point_1(p1_0), .point_2(p2_0),
        .Ovf(ovf0), .Busy(busy0), .Done(done0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse consumes one scoreboard entry.
    always @(negedge Clk) begin
        if (done1 || done0) begin
            check("done_pair", 32'(done0), 32'(done1));
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got disp=%h with empty scoreboard", disp1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result disp=%h plain=%h p1=%0d p2=%0d ovf=%0b", disp1, disp0, p1_1, p2_1, ovf1);
                check("disp_blank", disp1, e.d1);
                check("disp_plain", disp0, e.d0);
                check("point_1", 32'(p1_1), 32'(e.p1));
                check("point_2", 32'(p2_1), 32'(e.p2));
                check("ovf", 32'(ovf1), 32'(e.ovf));
                check("point_1_plain", 32'(p1_0), 32'(e.p1));
                check("ovf_plain", 32'(ovf0), 32'(e.ovf));
            end
        end
    end

    task automatic push(input logic [31:0] d1, input logic [31:0] d0,
                        input logic [2:0] p1, input logic [2:0] p2, input logic ovf);
        exp_t e;
        e.d1 = d1; e.d0 = d0; e.p1 = p1; e.p2 = p2; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [31:0] v);
        @(negedge Clk);
        Bin_Data  = v;
        Bin_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Bin_Valid = 1'b0;
    endtask

    // Single conversion with latency and Busy-width measurement.
    task automatic run(input logic [31:0] v);
        int n;
        int busy_cnt;
        pulse(v);
        busy_cnt = busy1 ? 1 : 0;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
            if (busy1) busy_cnt++;
        end while (!done1 && n < 40);
        check("latency", 32'(n), 32'd28);
        check("busy_cycles", 32'(busy_cnt), 32'd28);
        @(posedge Clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy1) && n < 300) begin
            @(posedge Clk);
            n++;
        end
        #1;
        check("drain", 32'(sb.size()), 32'd0);
        repeat (35) @(posedge Clk);
        #1;
    endtask

    logic [31:0] vin    [12] = '{32'd12_345, 32'd0, 32'd123_456_789, 32'd1_000_000,
                                 32'd99_999_999, 32'd100_000_000, 32'd999, 32'd1_000,
                                 32'd999_999, 32'hFFFF_FFFF, 32'd10_000_000, 32'd7};
    logic [31:0] vblank [12] = '{32'hFFF1_2345, 32'hFFFF_FFF0, 32'h9999_9999, 32'hF100_0000,
                                 32'h9999_9999, 32'h9999_9999, 32'hFFFF_F999, 32'hFFFF_1000,
                                 32'hFF99_9999, 32'h9999_9999, 32'h1000_0000, 32'hFFFF_FFF7};
    logic [31:0] vplain [12] = '{32'h0001_2345, 32'h0000_0000, 32'h9999_9999, 32'h0100_0000,
                                 32'h9999_9999, 32'h9999_9999, 32'h0000_0999, 32'h0000_1000,
                                 32'h0099_9999, 32'h9999_9999, 32'h1000_0000, 32'h0000_0007};
    logic [2:0]  vp1    [12] = '{3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    logic [2:0]  vp2    [12] = '{3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0};
    logic        vovf   [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int dcnt;
        Reset     = 1'b1;
        Bin_Data  = 32'd55;
        Bin_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        // Reset must win over a simultaneous Bin_Valid.
        @(negedge Clk);
        Bin_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Reset     = 1'b0;
        Bin_Valid = 1'b0;
        @(negedge Clk);
        check("rst_disp_blank", disp1, 32'hFFFF_FFF0);
        check("rst_disp_plain", disp0, 32'h0000_0000);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_points", 32'({p1_1, p2_1}), 32'd0);

        for (int i = 0; i < 12; i++) begin
            $display("vector %0d: bin=%0d", i, vin[i]);
            push(vblank[i], vplain[i], vp1[i], vp2[i], vovf[i]);
            run(vin[i]);
        end

        // Outputs hold between Done pulses.
        repeat (10) @(posedge Clk);
        #1;
        check("hold_disp", disp1, 32'hFFFF_FFF7);

        $display("sequence: 5 then 7,9 while busy");
        push(32'hFFFF_FFF5, 32'h0000_0005, 3'd0, 3'd0, 1'b0);
        push(32'hFFFF_FFF9, 32'h0000_0009, 3'd0, 3'd0, 1'b0);
        pulse(32'd5);
        repeat (3) @(posedge Clk);
        pulse(32'd7);
        repeat (2) @(posedge Clk);
        pulse(32'd9);
        wait_drain();

        $display("sequence: 300 then 8 during FORMAT");
        push(32'hFFFF_F300, 32'h0000_0300, 3'd0, 3'd0, 1'b0);
        push(32'hFFFF_FFF8, 32'h0000_0008, 3'd0, 3'd0, 1'b0);
        pulse(32'd300);
        repeat (27) @(posedge Clk);
        pulse(32'd8);
        wait_drain();

        $display("sequence: 40, pending 7 overridden by 11 in IDLE");
        push(32'hFFFF_FF40, 32'h0000_0040, 3'd0, 3'd0, 1'b0);
        push(32'hFFFF_FF11, 32'h0000_0011, 3'd0, 3'd0, 1'b0);
        pulse(32'd40);
        repeat (5) @(posedge Clk);
        pulse(32'd7);
        repeat (22) @(posedge Clk);
        pulse(32'd11);
        wait_drain();

        $display("sequence: reset 10 cycles into conversion of 42");
        pulse(32'd42);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_disp_blank", disp1, 32'hFFFF_FFF0);
        check("abort_disp_plain", disp0, 32'h0000_0000);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (done1 || done0) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
